// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, LSB first, one bit per clock,
// carry registered between bits; start/busy/done handshake.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, sampled only in IDLE
//   a, b            operands, captured on the accepting edge
//   sub             (SERIAL_SUB_EN only) subtract, captured with operands
//   busy            high in RUN and DONE
//   done            one-cycle pulse, result valid
//   sum             result, held until the next accepted start
//   c_out, ovf      unsigned carry out, two's-complement overflow
// Optional feature macro: SERIAL_SUB_EN (adds the sub port / a-b mode).
module serial_adder #(
  parameter int N  = 8,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_sr_q, a_sr_d;
  logic [N-1:0]  b_sr_q, b_sr_d;
  logic [N-1:0]  res_sr_q, res_sr_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cmsb_q, cmsb_d;
  logic          c_out_q, c_out_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The single full-adder cell shared by every bit position.
  logic fa_a, fa_b, fa_cin;
  logic fa_sum, fa_cout;

  assign fa_a    = a_sr_q[0];
  assign fa_b    = b_sr_q[0];
  assign fa_cin  = carry_q;
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  // Operand B and initial carry as loaded on accept; subtraction is
  // a + ~b + 1.
  logic [N-1:0] b_load;
  logic         c_load;

`ifdef SERIAL_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub;
`else
  assign b_load = b;
  assign c_load = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_sr_d = {fa_sum, res_sr_q[N-1:1]};
        a_sr_d   = {1'b0, a_sr_q[N-1:1]};
        b_sr_d   = {1'b0, b_sr_q[N-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        // Carry out of bit N-2 is the carry into the MSB.
        if (cnt_q == CW'(N-2)) begin
          cmsb_d = fa_cout;
        end
        if (cnt_q == CW'(N-1)) begin
          sum_d   = {fa_sum, res_sr_q[N-1:1]};
          c_out_d = fa_cout;
          ovf_d   = cmsb_q ^ fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (N=8).
// Subtraction vectors are included when SERIAL_SUB_EN is defined.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
`ifdef SERIAL_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, c_out, ovf;
  logic [N-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_adder #(.N(N), .CW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Pulse start with operands; returns #1 after the accepting edge.
  task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; runs until busy drops (bounded).
  // lat = edges after accept at which done was first seen (0 = never).
  task automatic wait_op(output int lat, output int busy_n,
                         output int done_n, output bit early);
    logic [N-1:0] s0;
    s0 = sum;
    lat = 0;
    done_n = 0;
    early = 1'b0;
    busy_n = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat == 0) lat = k;
      end else if (lat == 0 && sum !== s0) begin
        early = 1'b1;
      end
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rst_sum: got %h exp 00", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL rst_cout: got %b exp 0", c_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b exp 0", ovf); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bn, dn;
    bit early;
    launch(8'h3C, 8'h15);
    wait_op(lat, bn, dn, early);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d exp 8", lat); end
    checks++; if (bn !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d exp 9", bn); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_count: got %0d exp 1", dn); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_sum_early: got %b exp 0", early); end
    checks++; if (sum !== 8'h51) begin errors++; $display("FAIL basic_sum: got %h exp 51", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b exp 0", c_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b exp 0", ovf); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sum !== 8'h51) begin errors++; $display("FAIL idle_hold_sum: got %h exp 51", sum); end
  endtask

  task automatic test_carry_ovf();
    int lat, bn, dn;
    bit early;
    launch(8'hFF, 8'h01);
    wait_op(lat, bn, dn, early);
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL wrap_sum: got %h exp 00", sum); end
    checks++; if (c_out !== 1'b1) begin errors++; $display("FAIL wrap_cout: got %b exp 1", c_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b exp 0", ovf); end
    launch(8'h7F, 8'h01);
    wait_op(lat, bn, dn, early);
    checks++; if (sum !== 8'h80) begin errors++; $display("FAIL ovf_sum: got %h exp 80", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL ovf_cout: got %b exp 0", c_out); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_ovf: got %b exp 1", ovf); end
  endtask

  task automatic test_back_to_back();
    int lat, bn, dn;
    bit early;
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    @(posedge clk); #1;
    a = 8'hAA;
    b = 8'h55;
    wait_op(lat, bn, dn, early);
    checks++; if (dn !== 1) begin errors++; $display("FAIL held_done_count: got %0d exp 1", dn); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL held_latency: got %0d exp 8", lat); end
    checks++; if (sum !== 8'h30) begin errors++; $display("FAIL held_sum: got %h exp 30", sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_gap: got %b exp 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL second_accept: got %b exp 1", busy); end
    wait_op(lat, bn, dn, early);
    checks++; if (sum !== 8'hFF) begin errors++; $display("FAIL second_sum: got %h exp ff", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL second_cout: got %b exp 0", c_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL second_ovf: got %b exp 0", ovf); end
  endtask

  task automatic test_reset_abort();
    int lat, bn, dn;
    bit early;
    int dseen;
    launch(8'h0F, 8'h01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL abort_sum: got %h exp 00", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL abort_cout: got %b exp 0", c_out); end
    dseen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) dseen++;
      @(posedge clk); #1;
    end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d exp 0", dseen); end
    launch(8'h0F, 8'h01);
    wait_op(lat, bn, dn, early);
    checks++; if (sum !== 8'h10) begin errors++; $display("FAIL after_abort_sum: got %h exp 10", sum); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL after_abort_lat: got %0d exp 8", lat); end
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub();
    int lat, bn, dn;
    bit early;
    sub = 1'b1;
    launch(8'h05, 8'h07);
    sub = 1'b0;
    wait_op(lat, bn, dn, early);
    checks++; if (sum !== 8'hFE) begin errors++; $display("FAIL sub_sum: got %h exp fe", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL sub_cout: got %b exp 0", c_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf: got %b exp 0", ovf); end
    sub = 1'b1;
    launch(8'h80, 8'h01);
    sub = 1'b0;
    wait_op(lat, bn, dn, early);
    checks++; if (sum !== 8'h7F) begin errors++; $display("FAIL sub2_sum: got %h exp 7f", sum); end
    checks++; if (c_out !== 1'b1) begin errors++; $display("FAIL sub2_cout: got %b exp 1", c_out); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub2_ovf: got %b exp 1", ovf); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
